// File: rtl/types_amba_pkg.sv
// Shared AMBA/AXI4 system-bus types, widths and default attributes.
// Also holds the single-beat master FSM state encoding.
package types_amba_pkg;

    localparam int CFG_SYSBUS_ADDR_BITS       = 32;
    localparam int CFG_SYSBUS_DATA_BITS       = 64;
    localparam int CFG_SYSBUS_DATA_BYTES      = CFG_SYSBUS_DATA_BITS / 8;
    localparam int CFG_LOG2_SYSBUS_DATA_BYTES = 3;
    localparam int CFG_SYSBUS_ID_BITS         = 5;
    localparam int CFG_SYSBUS_USER_BITS       = 1;

    localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;
    localparam logic [2:0] AXI_SIZE_SYSBUS = 3'(CFG_LOG2_SYSBUS_DATA_BYTES);
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        AXI_MST_IDLE,
        AXI_MST_AR,
        AXI_MST_R,
        AXI_MST_AW_W,
        AXI_MST_B,
        AXI_MST_RESP
    } axi_mst_state_e;

    typedef struct packed {
        logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
        logic [7:0]                      len;
        logic [2:0]                      size;
        logic [1:0]                      burst;
        logic                            lock;
        logic [3:0]                      cache;
        logic [2:0]                      prot;
        logic [3:0]                      qos;
        logic [3:0]                      region;
    } axi4_metadata_type;

    typedef struct packed {
        logic                             aw_valid;
        axi4_metadata_type                aw_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]    aw_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  aw_user;
        logic                             w_valid;
        logic [CFG_SYSBUS_DATA_BITS-1:0]  w_data;
        logic                             w_last;
        logic [CFG_SYSBUS_DATA_BYTES-1:0] w_strb;
        logic [CFG_SYSBUS_USER_BITS-1:0]  w_user;
        logic                             b_ready;
        logic                             ar_valid;
        axi4_metadata_type                ar_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]    ar_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  ar_user;
        logic                             r_ready;
    } axi4_master_out_type;

    typedef struct packed {
        logic                             aw_ready;
        logic                             w_ready;
        logic                             b_valid;
        logic [1:0]                       b_resp;
        logic [CFG_SYSBUS_ID_BITS-1:0]    b_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  b_user;
        logic                             ar_ready;
        logic                             r_valid;
        logic [1:0]                       r_resp;
        logic [CFG_SYSBUS_DATA_BITS-1:0]  r_data;
        logic                             r_last;
        logic [CFG_SYSBUS_ID_BITS-1:0]    r_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  r_user;
    } axi4_master_in_type;

endpackage

// File: rtl/axi_mst.sv
// Single-outstanding AXI4 master: turns one simple request into a single-beat
// AXI read or write and returns data/error through a held response strobe.
module axi_mst
    import types_amba_pkg::*;
#(
    parameter logic [CFG_SYSBUS_ID_BITS-1:0]   req_id    = '0,
    parameter logic [CFG_SYSBUS_USER_BITS-1:0] user_bits = '0
) (
    input  logic                             i_clk,
    input  logic                             i_nrst,
    input  logic                             i_req_valid,
    input  logic [CFG_SYSBUS_ADDR_BITS-1:0]  i_req_addr,
    input  logic                             i_req_write,
    input  logic [CFG_SYSBUS_DATA_BITS-1:0]  i_req_wdata,
    input  logic [CFG_SYSBUS_DATA_BYTES-1:0] i_req_wstrb,
    output logic                             o_req_ready,
    output logic                             o_resp_valid,
    output logic [CFG_SYSBUS_DATA_BITS-1:0]  o_resp_rdata,
    output logic                             o_resp_err,
    input  logic                             i_resp_ready,
    input  axi4_master_in_type               i_msti,
    output axi4_master_out_type              o_msto
);

    // Handshake rule on every channel: a transfer happens in a cycle where
    // valid and ready are both 1; valid never drops before that cycle and the
    // payload is held constant while valid waits for ready.

    axi_mst_state_e                   r_state;
    axi_mst_state_e                   w_state_next;
    logic [CFG_SYSBUS_ADDR_BITS-1:0]  r_addr;
    logic                             r_write;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  r_wdata;
    logic [CFG_SYSBUS_DATA_BYTES-1:0] r_wstrb;
    logic                             r_aw_done;
    logic                             r_w_done;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  r_rdata;
    logic                             r_err;

    logic w_ar_valid;
    logic w_r_ready;
    logic w_aw_valid;
    logic w_w_valid;
    logic w_b_ready;
    logic w_unused;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= AXI_MST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        w_ar_valid   = 1'b0;
        w_r_ready    = 1'b0;
        w_aw_valid   = 1'b0;
        w_w_valid    = 1'b0;
        w_b_ready    = 1'b0;
        case (r_state)
            AXI_MST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_state_next = i_req_write ? AXI_MST_AW_W : AXI_MST_AR;
                end
            end
            AXI_MST_AR: begin
                w_ar_valid = 1'b1;
                if (i_msti.ar_ready) w_state_next = AXI_MST_R;
            end
            AXI_MST_R: begin
                w_r_ready = 1'b1;
                if (i_msti.r_valid) w_state_next = AXI_MST_RESP;
            end
            AXI_MST_AW_W: begin
                // AW and W complete independently; leave once both are done.
                w_aw_valid = !r_aw_done;
                w_w_valid  = !r_w_done;
                if ((r_aw_done || i_msti.aw_ready) && (r_w_done || i_msti.w_ready)) begin
                    w_state_next = AXI_MST_B;
                end
            end
            AXI_MST_B: begin
                w_b_ready = 1'b1;
                if (i_msti.b_valid) w_state_next = AXI_MST_RESP;
            end
            AXI_MST_RESP: begin
                o_resp_valid = 1'b1;
                if (i_resp_ready) w_state_next = AXI_MST_IDLE;
            end
            default: w_state_next = AXI_MST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                AXI_MST_IDLE: begin
                    if (i_req_valid) begin
                        r_addr    <= i_req_addr;
                        r_write   <= i_req_write;
                        r_wdata   <= i_req_wdata;
                        r_wstrb   <= i_req_wstrb;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                AXI_MST_AW_W: begin
                    if (i_msti.aw_ready) r_aw_done <= 1'b1;
                    if (i_msti.w_ready)  r_w_done  <= 1'b1;
                end
                AXI_MST_R: begin
                    if (i_msti.r_valid) begin
                        r_rdata <= i_msti.r_data;
                        r_err   <= i_msti.r_resp[1];
                    end
                end
                AXI_MST_B: begin
                    if (i_msti.b_valid) r_err <= i_msti.b_resp[1];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_msto                = '0;
        o_msto.ar_valid       = w_ar_valid;
        o_msto.ar_bits.addr   = r_addr;
        o_msto.ar_bits.len    = AXI_LEN_SINGLE;
        o_msto.ar_bits.size   = AXI_SIZE_SYSBUS;
        o_msto.ar_bits.burst  = AXI_BURST_INCR;
        o_msto.ar_id          = req_id;
        o_msto.ar_user        = user_bits;
        o_msto.r_ready        = w_r_ready;
        o_msto.aw_valid       = w_aw_valid;
        o_msto.aw_bits.addr   = r_addr;
        o_msto.aw_bits.len    = AXI_LEN_SINGLE;
        o_msto.aw_bits.size   = AXI_SIZE_SYSBUS;
        o_msto.aw_bits.burst  = AXI_BURST_INCR;
        o_msto.aw_id          = req_id;
        o_msto.aw_user        = user_bits;
        o_msto.w_valid        = w_w_valid;
        o_msto.w_data         = r_wdata;
        o_msto.w_strb         = r_wstrb;
        o_msto.w_last         = 1'b1;
        o_msto.w_user         = user_bits;
        o_msto.b_ready        = w_b_ready;
    end

    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = r_err;

    // IDs, user bits, r_last and the low response bit carry no meaning here.
    assign w_unused = ^{r_write, i_msti.b_id, i_msti.b_user, i_msti.r_id, i_msti.r_user,
                        i_msti.r_last, i_msti.r_resp[0], i_msti.b_resp[0]};

endmodule

// File: tb/tb_axi_mst.sv
// Bench for axi_mst: reactive single-beat AXI slave, table-driven transactions,
// response scoreboard and channel protocol monitor.
module tb_axi_mst;
  import types_amba_pkg::*;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] sl_rdata;
    logic [1:0]  sl_resp;
    int          ar_d;
    int          aw_d;
    int          w_d;
    int          r_d;
    int          b_d;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic                clk;
  logic                rst_n;
  logic                i_req_valid;
  logic [31:0]         i_req_addr;
  logic                i_req_write;
  logic [63:0]         i_req_wdata;
  logic [7:0]          i_req_wstrb;
  logic                o_req_ready;
  logic                o_resp_valid;
  logic [63:0]         o_resp_rdata;
  logic                o_resp_err;
  logic                i_resp_ready;
  axi4_master_in_type  i_msti;
  axi4_master_out_type o_msto;

  int n_checks = 0;
  int n_errors = 0;
  int n_rd = 0;
  int n_wr = 0;
  int n_ar_hs = 0;
  int n_aw_hs = 0;
  int n_w_hs = 0;
  int n_b_hs = 0;

  logic [64:0] exp_q[$];
  logic [31:0] ar_exp_q[$];
  logic [31:0] aw_exp_q[$];
  logic [71:0] w_exp_q[$];

  // slave configuration
  int          cfg_ar_d = 0;
  int          cfg_aw_d = 0;
  int          cfg_w_d = 0;
  int          cfg_r_d = 0;
  int          cfg_b_d = 0;
  logic [63:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = 2'b00;
  logic [1:0]  cfg_bresp = 2'b00;
  logic        cfg_r_from_addr = 1'b0;
  logic        force_r_valid = 1'b0;
  logic [31:0] lat_ar = '0;

  vec_t vecs[8];

  axi_mst #(.req_id(5'h03), .user_bits(1'b1)) dut (
    .i_clk        (clk),
    .i_nrst       (rst_n),
    .i_req_valid  (i_req_valid),
    .i_req_addr   (i_req_addr),
    .i_req_write  (i_req_write),
    .i_req_wdata  (i_req_wdata),
    .i_req_wstrb  (i_req_wstrb),
    .o_req_ready  (o_req_ready),
    .o_resp_valid (o_resp_valid),
    .o_resp_rdata (o_resp_rdata),
    .o_resp_err   (o_resp_err),
    .i_resp_ready (i_resp_ready),
    .i_msti       (i_msti),
    .o_msto       (o_msto)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  function automatic vec_t mk(logic wr, logic [31:0] a, logic [63:0] wd, logic [7:0] ws,
                              logic [63:0] sd, logic [1:0] rs, int ard, int awd, int wdl,
                              int rd, int bd, logic [63:0] er, logic ee);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.wstrb = ws; v.sl_rdata = sd; v.sl_resp = rs;
    v.ar_d = ard; v.aw_d = awd; v.w_d = wdl; v.r_d = rd; v.b_d = bd;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  // ---------------- AXI slave model ----------------
  initial begin
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    i_msti = '0;
    forever begin
      @(posedge clk);
      #1;
      i_msti = '0;
      i_msti.r_id = 5'($urandom_range(0, 31));
      i_msti.b_id = 5'($urandom_range(0, 31));
      if (!rst_n) begin
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
      end else begin
        if (o_msto.ar_valid) begin
          i_msti.ar_ready = (ar_cnt >= cfg_ar_d);
          ar_cnt++;
        end else ar_cnt = 0;
        if (o_msto.aw_valid) begin
          i_msti.aw_ready = (aw_cnt >= cfg_aw_d);
          aw_cnt++;
        end else aw_cnt = 0;
        if (o_msto.w_valid) begin
          i_msti.w_ready = (w_cnt >= cfg_w_d);
          w_cnt++;
        end else w_cnt = 0;
        if (o_msto.r_ready) begin
          if (r_cnt >= cfg_r_d) begin
            i_msti.r_valid = 1'b1;
            i_msti.r_last  = 1'b1;
            i_msti.r_data  = cfg_r_from_addr ? {lat_ar, ~lat_ar} : cfg_rdata;
            i_msti.r_resp  = cfg_rresp;
          end
          r_cnt++;
        end else r_cnt = 0;
        if (o_msto.b_ready) begin
          if (b_cnt >= cfg_b_d) begin
            i_msti.b_valid = 1'b1;
            i_msti.b_resp  = cfg_bresp;
          end
          b_cnt++;
        end else b_cnt = 0;
      end
      if (force_r_valid) begin
        i_msti.r_valid = 1'b1;
        i_msti.r_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        i_msti.r_resp  = AXI_RESP_OKAY;
      end
    end
  end

  // ---------------- monitor + scoreboard ----------------
  logic        p_ar_pend = 0, p_aw_pend = 0, p_w_pend = 0, p_aw_hs = 0, p_w_hs = 0;
  logic [31:0] p_ar_addr = '0, p_aw_addr = '0;
  logic [71:0] p_w_pay = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_ar_pend = 0; p_aw_pend = 0; p_w_pend = 0; p_aw_hs = 0; p_w_hs = 0;
    end else begin
      if (p_ar_pend) chk("ar_hold", {o_msto.ar_valid, o_msto.ar_bits.addr}, {1'b1, p_ar_addr});
      if (p_aw_pend) chk("aw_hold", {o_msto.aw_valid, o_msto.aw_bits.addr}, {1'b1, p_aw_addr});
      if (p_w_pend)  chk("w_hold", {o_msto.w_valid, o_msto.w_data, o_msto.w_strb}, {1'b1, p_w_pay});
      if (p_aw_hs)   chk("aw_drop", o_msto.aw_valid, 1'b0);
      if (p_w_hs)    chk("w_drop", o_msto.w_valid, 1'b0);
      if (o_msto.ar_valid || o_msto.aw_valid || o_msto.w_valid)
        chk("one_txn", o_msto.ar_valid && (o_msto.aw_valid || o_msto.w_valid), 1'b0);

      if (o_msto.ar_valid && i_msti.ar_ready) begin
        n_ar_hs++;
        if (ar_exp_q.size() == 0) fail_msg("ar_unexpected");
        else chk("ar_addr", o_msto.ar_bits.addr, ar_exp_q.pop_front());
        chk("ar_ctl", {o_msto.ar_bits.len, o_msto.ar_bits.size, o_msto.ar_bits.burst, o_msto.ar_id,
                       o_msto.ar_user, o_msto.ar_bits.prot, o_msto.ar_bits.cache,
                       o_msto.ar_bits.lock, o_msto.ar_bits.qos},
            {8'h00, 3'd3, 2'b01, 5'h03, 1'b1, 3'b000, 4'h0, 1'b0, 4'h0});
        lat_ar = o_msto.ar_bits.addr;
      end
      if (o_msto.aw_valid && i_msti.aw_ready) begin
        n_aw_hs++;
        if (aw_exp_q.size() == 0) fail_msg("aw_unexpected");
        else chk("aw_addr", o_msto.aw_bits.addr, aw_exp_q.pop_front());
        chk("aw_ctl", {o_msto.aw_bits.len, o_msto.aw_bits.size, o_msto.aw_bits.burst, o_msto.aw_id,
                       o_msto.aw_user, o_msto.aw_bits.prot, o_msto.aw_bits.cache,
                       o_msto.aw_bits.lock, o_msto.aw_bits.qos},
            {8'h00, 3'd3, 2'b01, 5'h03, 1'b1, 3'b000, 4'h0, 1'b0, 4'h0});
      end
      if (o_msto.w_valid && i_msti.w_ready) begin
        n_w_hs++;
        if (w_exp_q.size() == 0) fail_msg("w_unexpected");
        else chk("w_data", {o_msto.w_data, o_msto.w_strb}, w_exp_q.pop_front());
        chk("w_last_user", {o_msto.w_last, o_msto.w_user}, 2'b11);
      end
      if (o_msto.b_ready && i_msti.b_valid) n_b_hs++;

      if (o_resp_valid && i_resp_ready) begin
        if (exp_q.size() == 0) fail_msg("resp_unexpected");
        else chk("resp", {o_resp_rdata, o_resp_err}, exp_q.pop_front());
      end

      p_ar_pend = o_msto.ar_valid && !i_msti.ar_ready;
      p_ar_addr = o_msto.ar_bits.addr;
      p_aw_pend = o_msto.aw_valid && !i_msti.aw_ready;
      p_aw_addr = o_msto.aw_bits.addr;
      p_w_pend  = o_msto.w_valid && !i_msti.w_ready;
      p_w_pay   = {o_msto.w_data, o_msto.w_strb};
      p_aw_hs   = o_msto.aw_valid && i_msti.aw_ready;
      p_w_hs    = o_msto.w_valid && i_msti.w_ready;
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [63:0] wd,
                        input logic [7:0] ws, input logic [63:0] er, input logic ee,
                        input bit push_resp);
    bit ok;
    i_req_valid = 1'b1;
    i_req_write = wr;
    i_req_addr  = a;
    i_req_wdata = wd;
    i_req_wstrb = ws;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (o_req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_msg("accept_timeout");
    else begin
      if (push_resp) exp_q.push_back({er, ee});
      if (wr) begin
        aw_exp_q.push_back(a);
        w_exp_q.push_back({wd, ws});
        n_wr++;
      end else begin
        ar_exp_q.push_back(a);
        n_rd++;
      end
    end
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && o_req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_msg("idle_timeout");
  endtask

  task automatic set_slave(input vec_t v);
    cfg_ar_d = v.ar_d; cfg_aw_d = v.aw_d; cfg_w_d = v.w_d; cfg_r_d = v.r_d; cfg_b_d = v.b_d;
    cfg_rdata = v.sl_rdata; cfg_rresp = v.sl_resp; cfg_bresp = v.sl_resp;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] ra, wa;
    logic [63:0] rd64, wd64;
    logic [7:0]  ws8;
    logic [1:0]  rr, br;
    bit          ok;

    rst_n = 1'b0;
    i_req_valid = 1'b0; i_req_write = 1'b0; i_req_addr = '0; i_req_wdata = '0; i_req_wstrb = '0;
    i_resp_ready = 1'b1;

    ra = {13'h0, 16'($urandom_range(0, 65535)), 3'b000};
    rd64 = {$urandom(), $urandom()};
    rr = 2'($urandom_range(0, 3));
    wa = {13'h1, 16'($urandom_range(0, 65535)), 3'b000};
    wd64 = {$urandom(), $urandom()};
    ws8 = 8'($urandom_range(1, 255));
    br = 2'($urandom_range(0, 3));

    vecs[0] = mk(0, 32'h1800, 64'h0, 8'h00, 64'h0F1E2D3C4B5A6978, AXI_RESP_OKAY, 1, 0, 0, 1, 0, 64'h0F1E2D3C4B5A6978, 1'b0);
    vecs[1] = mk(1, 32'h2008, 64'hA5, 8'h01, 64'h0, AXI_RESP_OKAY, 0, 2, 0, 0, 0, 64'h0F1E2D3C4B5A6978, 1'b0);
    vecs[2] = mk(0, 32'h3000, 64'h0, 8'h00, 64'hDEADBEEFCAFEF00D, AXI_RESP_DECERR, 2, 0, 0, 2, 0, 64'hDEADBEEFCAFEF00D, 1'b1);
    vecs[3] = mk(1, 32'h4010, 64'h0123456789ABCDEF, 8'hFF, 64'h0, AXI_RESP_SLVERR, 0, 0, 3, 0, 1, 64'hDEADBEEFCAFEF00D, 1'b1);
    vecs[4] = mk(0, 32'h4800, 64'h0, 8'h00, 64'h0123456789ABCDEF, AXI_RESP_EXOKAY, 0, 0, 0, 0, 0, 64'h0123456789ABCDEF, 1'b0);
    vecs[5] = mk(1, 32'h5008, 64'hFFFF0000, 8'h0F, 64'h0, AXI_RESP_EXOKAY, 0, 1, 1, 0, 2, 64'h0123456789ABCDEF, 1'b0);
    vecs[6] = mk(0, ra, 64'h0, 8'h00, rd64, rr, $urandom_range(0, 2), 0, 0, $urandom_range(0, 2), 0, rd64, rr[1]);
    vecs[7] = mk(1, wa, wd64, ws8, 64'h0, br, 0, $urandom_range(0, 3), $urandom_range(0, 3), 0, $urandom_range(0, 2), rd64, br[1]);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_outputs", {o_msto.ar_valid, o_msto.aw_valid, o_msto.w_valid, o_msto.r_ready,
                        o_msto.b_ready, o_resp_valid, o_resp_err, o_resp_rdata}, '0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", o_req_ready, 1'b1);

    // minimum read latency: accept cycle 0, AR cycle 1, response cycle 3
    cfg_ar_d = 0; cfg_r_d = 0; cfg_rdata = 64'h1122334455667788; cfg_rresp = AXI_RESP_OKAY;
    do_req(0, 32'h1000, '0, '0, 64'h1122334455667788, 1'b0, 1);
    @(negedge clk);
    chk("lat_cyc1_ar", {o_msto.ar_valid, o_resp_valid}, 2'b10);
    @(negedge clk);
    chk("lat_cyc2_r", {o_msto.r_ready, o_resp_valid}, 2'b10);
    @(negedge clk);
    chk("lat_cyc3_resp", {o_resp_valid, o_resp_rdata, o_resp_err}, {1'b1, 64'h1122334455667788, 1'b0});
    wait_idle();

    // table-driven transactions
    for (int i = 0; i < 8; i++) begin
      set_slave(vecs[i]);
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
             vecs[i].exp_rdata, vecs[i].exp_err, 1);
      wait_idle();
    end

    // response held while i_resp_ready is low
    cfg_ar_d = 0; cfg_r_d = 0; cfg_rdata = 64'h55AA000012345678; cfg_rresp = AXI_RESP_OKAY;
    i_resp_ready = 1'b0;
    do_req(0, 32'h5000, '0, '0, 64'h55AA000012345678, 1'b0, 1);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_resp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_msg("hold_resp_timeout");
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("resp_hold", {o_resp_valid, o_resp_rdata, o_resp_err, o_req_ready},
          {1'b1, 64'h55AA000012345678, 1'b0, 1'b0});
    end
    @(posedge clk);
    #1;
    i_resp_ready = 1'b1;
    wait_idle();

    // reset while waiting in R after the AR handshake
    cfg_ar_d = 1; cfg_r_d = 30;
    do_req(0, 32'h6000, '0, '0, '0, 1'b0, 0);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_msto.r_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_msg("reach_r_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {o_msto.ar_valid, o_msto.aw_valid, o_msto.w_valid, o_msto.r_ready,
                            o_msto.b_ready, o_resp_valid, o_resp_err, o_resp_rdata}, '0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_mid_rst", o_req_ready, 1'b1);
    force_r_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("late_r_ignored", {o_msto.r_ready, o_resp_valid, o_req_ready}, 3'b001);
    end
    @(posedge clk);
    #1;
    force_r_valid = 1'b0;
    cfg_ar_d = 0; cfg_r_d = 0;

    // back-to-back read / write / read
    cfg_r_from_addr = 1'b1; cfg_rresp = AXI_RESP_OKAY; cfg_bresp = AXI_RESP_OKAY;
    cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0;
    do_req(0, 32'h7000, '0, '0, {32'h7000, ~32'h7000}, 1'b0, 1);
    do_req(1, 32'h7100, 64'hCAFE, 8'h03, {32'h7000, ~32'h7000}, 1'b0, 1);
    do_req(0, 32'h7200, '0, '0, {32'h7200, ~32'h7200}, 1'b0, 1);
    wait_idle();

    // end-of-test accounting
    chk("resp_q_empty", exp_q.size(), 0);
    chk("aw_w_b_counts", {n_aw_hs[15:0], n_w_hs[15:0], n_b_hs[15:0]}, {n_wr[15:0], n_wr[15:0], n_wr[15:0]});
    chk("ar_count", n_ar_hs, n_rd);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
